// File: rtl/operand_loader_pkg.sv
// Shared defaults and FSM state encodings for the operand loader and its controller.
package operand_loader_pkg;

    localparam int unsigned N_INPUT_DEFAULT = 16;
    localparam int unsigned N_MULT_DEFAULT  = 8;

    typedef enum logic [1:0] {
        StFill  = 2'd0,
        StLast  = 2'd1,
        StStart = 2'd2,
        StWait  = 2'd3
    } load_state_e;

endpackage

// File: rtl/load_counter.sv
// Write-address counter for the input RAM; saturates at the terminal count R-1 and
// only returns to zero through clr.
module load_counter #(
    parameter int unsigned AW = 4,
    parameter int unsigned R  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] count,
    output logic          co
);

    localparam logic [AW-1:0] TermCount = AW'(R - 1);

    logic [AW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && !co) begin
            count_q <= count_q + AW'(1);
        end
    end

    assign count = count_q;
    assign co    = (count_q == TermCount);

endmodule

// File: rtl/operand_loader.sv
// Feed stage: packs streamed operands into the input RAM as A/B pairs, pulses start,
// then holds off input until done_i. Optional zero-operand flags under ZERO_DETECT_EN.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned N_INPUT           = N_INPUT_DEFAULT,
    parameter int unsigned N_MULTIPLICATIONS = N_MULT_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    clr,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [N_INPUT-1:0]                      in_data,
    output logic                                    wr,
    output logic [$clog2(2*N_MULTIPLICATIONS)-1:0]  wr_addr,
    output logic [N_INPUT-1:0]                      wr_data,
    output logic                                    start,
    input  logic                                    done_i,
    output logic                                    busy,
    output logic [7:0]                              batch_cnt,
    output logic [N_MULTIPLICATIONS-1:0]            zero_flags
);

    localparam int unsigned R  = 2 * N_MULTIPLICATIONS;
    localparam int unsigned AW = $clog2(R);

    load_state_e       state_q, state_d;
    logic [AW-1:0]     addr;
    logic              addr_co;
    logic              hs;
    logic              done_acc;
    logic              wr_q;
    logic [AW-1:0]     wr_addr_q;
    logic [N_INPUT-1:0] wr_data_q;
    logic [7:0]        batch_q;

    assign in_ready = (state_q == StFill) & ~clr;
    assign hs       = in_valid & in_ready;
    assign done_acc = (state_q == StWait) & done_i & ~clr;

    load_counter #(
        .AW (AW),
        .R  (R)
    ) u_load_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr | done_acc),
        .inc   (hs),
        .count (addr),
        .co    (addr_co)
    );

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = StFill;
        end else begin
            unique case (state_q)
                StFill:  if (hs && addr_co) state_d = StLast;
                StLast:  state_d = StStart;
                StStart: state_d = StWait;
                StWait:  if (done_i) state_d = StFill;
                default: state_d = StFill;
            endcase
        end
    end

    // in_ready is low under clr, so a same-cycle handshake can never reach the RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFill;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            batch_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= hs;
            if (hs) begin
                wr_addr_q <= addr;
                wr_data_q <= in_data;
            end
            if (done_acc) begin
                batch_q <= batch_q + 8'd1;
            end
        end
    end

    assign wr        = wr_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign start     = (state_q == StStart);
    assign busy      = (state_q != StFill);
    assign batch_cnt = batch_q;

`ifdef ZERO_DETECT_EN
    logic [N_MULTIPLICATIONS-1:0] zero_q, zero_d;

    // Pair index is the address with the A/B select bit dropped.
    always_comb begin
        zero_d = zero_q;
        if (clr || done_acc) begin
            zero_d = '0;
        end else if (hs && (in_data == '0)) begin
            zero_d[addr[AW-1:1]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_q <= '0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero_flags = zero_q;
`else
    assign zero_flags = '0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: a batch-level model predicts writes, start
// pulses, flags and counters; a negedge monitor compares them against the DUT.
module tb_operand_loader;

    localparam int R = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        done_i = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        wr;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        busy;
    logic [7:0]  batch_cnt;
    logic [7:0]  zero_flags;

    operand_loader #(
        .N_INPUT           (16),
        .N_MULTIPLICATIONS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .wr         (wr),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .done_i     (done_i),
        .busy       (busy),
        .batch_cnt  (batch_cnt),
        .zero_flags (zero_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_exp_t;

    wr_exp_t wq[$];
    int      sq[$];
    wr_exp_t mon_e;
    int      mon_s;

    // Batch-level reference state: words accepted so far, whether loading is open,
    // and the values the DUT should show this cycle (vis_*) and next cycle (nxt_*).
    bit       m_filling = 1'b1;
    bit       nxt_filling = 1'b1;
    int       m_count = 0;
    int       m_load_cyc = -100;
    int       vis_batch = 0;
    int       nxt_batch = 0;
    bit [7:0] vis_flags = '0;
    bit [7:0] nxt_flags = '0;
    bit       exp_ready = 1'b1;
    bit       exp_busy = 1'b0;
    bit       mon_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit dn, input bit c);
        @(posedge clk);
        #1;
        m_filling = nxt_filling;
        vis_batch = nxt_batch;
        vis_flags = nxt_flags;
        in_valid  = v;
        in_data   = d;
        done_i    = dn;
        clr       = c;
        exp_ready = m_filling && !c;
        exp_busy  = !m_filling;
        if (c) begin
            nxt_filling = 1'b1;
            m_count     = 0;
            nxt_flags   = '0;
        end else if (v && exp_ready) begin
            wq.push_back('{cyc + 1, m_count, int'(d)});
`ifdef ZERO_DETECT_EN
            if (d == 16'd0) nxt_flags[m_count / 2] = 1'b1;
`endif
            m_count++;
            if (m_count == R) begin
                nxt_filling = 1'b0;
                m_load_cyc  = cyc;
                sq.push_back(cyc + 2);
            end
        end else if (dn && !m_filling && cyc >= m_load_cyc + 3) begin
            nxt_batch   = (nxt_batch + 1) % 256;
            m_count     = 0;
            nxt_filling = 1'b1;
            nxt_flags   = '0;
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        done_i   = 1'b0;
        clr      = 1'b0;
        #2;
        chk("rst_wr", wr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_start", start, 0);
        chk("rst_batch_cnt", batch_cnt, 0);
        chk("rst_zero_flags", zero_flags, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        m_filling   = 1'b1;
        nxt_filling = 1'b1;
        m_count     = 0;
        m_load_cyc  = -100;
        vis_batch   = 0;
        nxt_batch   = 0;
        vis_flags   = '0;
        nxt_flags   = '0;
        wq.delete();
        sq.delete();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        exp_ready = 1'b1;
        exp_busy  = 1'b0;
        mon_en    = 1'b1;
    endtask

    // Finish the batch: a few idle cycles, then done_i until the model accepts it.
    task automatic drain_done(input int idle);
        int g;
        repeat (idle) step(1'b0, 16'd0, 1'b0, 1'b0);
        g = 0;
        do begin
            step(1'b0, 16'd0, 1'b1, 1'b0);
            g++;
        end while (!nxt_filling && g < 6);
        step(1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", in_ready, exp_ready);
            chk("busy", busy, exp_busy);
            chk("batch_cnt", batch_cnt, vis_batch);
            chk("zero_flags", zero_flags, vis_flags);
            if (wr) begin
                chk("wr_expected", wq.size() != 0, 1);
                if (wq.size() != 0) begin
                    mon_e = wq.pop_front();
                    chk("wr_cycle", cyc, mon_e.cyc);
                    chk("wr_addr", wr_addr, mon_e.addr);
                    chk("wr_data", wr_data, mon_e.data);
                end
            end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
                chk("wr_present", wr, 1);
                void'(wq.pop_front());
            end
            if (start) begin
                chk("start_expected", sq.size() != 0, 1);
                if (sq.size() != 0) begin
                    mon_s = sq.pop_front();
                    chk("start_cycle", cyc, mon_s);
                end
            end else if (sq.size() != 0 && sq[0] <= cyc) begin
                chk("start_present", start, 1);
                void'(sq.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit       tog;
        int       g;
        bit [7:0] exp_zf;

        do_reset();

        // Back-to-back batch 1..16; done_i in the START cycle must be lost.
        for (int i = 1; i <= R; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0);
        drain_done(3);

        // Backpressure: in_valid toggles every cycle.
        tog = 1'b1;
        g = 0;
        while (nxt_filling && g < 100) begin
            step(tog, 16'($urandom_range(1, 16'hffff)), 1'b0, 1'b0);
            tog = ~tog;
            g++;
        end
        drain_done(2);

        // Spurious done_i in FILL after 5 words.
        for (int i = 0; i < 5; i++) step(1'b1, 16'(100 + i), 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b1, 1'b0);
        for (int i = 5; i < R; i++) step(1'b1, 16'(100 + i), 1'b0, 1'b0);
        drain_done(2);

        // clr on the 10th handshake, then a full refill.
        for (int i = 0; i < 9; i++) step(1'b1, 16'(200 + i), 1'b0, 1'b0);
        step(1'b1, 16'd209, 1'b0, 1'b1);
        for (int i = 0; i < R; i++) step(1'b1, 16'(300 + i), 1'b0, 1'b0);
        drain_done(2);

        // Zero operands at A3 (addr 6) and B6 (addr 13).
        for (int i = 0; i < R; i++) begin
            step(1'b1, (i == 6 || i == 13) ? 16'd0 : 16'(400 + i), 1'b0, 1'b0);
        end
        step(1'b0, 16'd0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b0, 1'b0);
`ifdef ZERO_DETECT_EN
        exp_zf = 8'b0100_1000;
`else
        exp_zf = 8'b0000_0000;
`endif
        chk("start_at_zero_batch", start, 1);
        chk("zero_flags_at_start", zero_flags, exp_zf);
        drain_done(1);
        chk("zero_flags_cleared", zero_flags, 0);

        // Randomised batches with occasional zeros, aborts and stray done_i.
        for (int b = 0; b < 6; b++) begin
            g = 0;
            while (nxt_filling && g < 300) begin
                step($urandom_range(0, 9) < 7,
                     ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom),
                     $urandom_range(0, 19) == 0,
                     (b == 2 && g == 7));
                g++;
            end
            drain_done($urandom_range(1, 5));
        end

        // Reset asserted while waiting for done_i.
        for (int i = 0; i < R; i++) step(1'b1, 16'(500 + i), 1'b0, 1'b0);
        repeat (4) step(1'b0, 16'd0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 16'd7, 1'b0, 1'b0);
        repeat (3) step(1'b0, 16'd0, 1'b0, 1'b0);

        mon_en = 1'b0;
        chk("wr_queue_drained", wq.size(), 0);
        chk("start_queue_drained", sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
